dco_arr_slew_cod: RTL and testbench

- Registered, rate-limited row/column encoder for the DCO capacitor-array tuning banks.
- Accepts a binary target tuning word and walks an internal current word toward it in bounded steps at a programmable tick rate, so the array never sees large code jumps.
- Each current word is encoded into active-low row-all, one-hot row and column-thermometer selectors, registered at the output.
- Generalises the square array to independent row/column widths with selectable serpentine or linear column fill; sits between the loop-filter/tuning-word logic and the DCO array.

---
 rtl/dco_arr_slew_cod.sv | 155 +++++++++++++++
 tb/tb_dco_arr_slew_cod.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_arr_slew_cod.sv
// dco_arr_slew_cod: rate-limited row/column encoder for DCO capacitor-array tuning banks.
//
// A binary target word is loaded via word/word_vld. An internal current word walks toward
// the target by at most MAX_STEP per tick (one tick every TICK_DIV enabled cycles), so the
// array never sees large code jumps. jump=1 with word_vld loads the current word directly.
// The current word is encoded into active-low fully-on rows, a one-hot partial row and a
// column thermometer for the partial row, all registered (one cycle after cur_word).
//
// Ports:
//   clk       clock
//   rst       asynchronous reset, active high
//   en        step enable; low freezes the tick counter and the current word
//   word      target tuning word
//   word_vld  load word as the new target this cycle
//   jump      with word_vld: also load the current word, bypassing the slew limit
//   r_all     fully-on rows, active low (bit i = 0 iff i < row_bin)
//   row       one-hot partially-filled row
//   col       column thermometer for the partial row
//   cur_word  current (slewed) word
//   busy      high while cur_word != target
//
// WORD_W must equal ROW_W + COL_W; any other value is illegal.
module dco_arr_slew_cod #(
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned COL_W    = 4,
  parameter int unsigned WORD_W   = ROW_W + COL_W,
  parameter int unsigned MAX_STEP = 4,
  parameter int unsigned TICK_DIV = 2,
  parameter int unsigned SERP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORD_W-1:0]     word,
  input  logic                  word_vld,
  input  logic                  jump,
  output logic [2**ROW_W-1:0]   r_all,
  output logic [2**ROW_W-1:0]   row,
  output logic [2**COL_W-1:0]   col,
  output logic [WORD_W-1:0]     cur_word,
  output logic                  busy
);

  localparam int NROW = 2 ** ROW_W;
  localparam int NCOL = 2 ** COL_W;

  // A 1-bit counter is kept even for TICK_DIV == 1; it then stays at 0.
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

  // One extra bit so the step arithmetic can never wrap past 0 or the top code.
  localparam logic [WORD_W:0] Step = (WORD_W + 1)'(MAX_STEP);

  logic [WORD_W-1:0] target_q, target_d;
  logic [WORD_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NROW-1:0]   r_all_q, r_all_d;
  logic [NROW-1:0]   row_q, row_d;
  logic [NCOL-1:0]   col_q, col_d;

  logic              tick;
  logic [WORD_W-1:0] step_word;
  logic [WORD_W:0]   cur_x, tgt_x, diff, moved;

  logic [ROW_W-1:0]  row_bin;
  logic [COL_W-1:0]  col_bin;

  // Tick counter: advances only while enabled, free-running regardless of busy.
  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Bounded step toward the registered target.
  always_comb begin
    cur_x     = {1'b0, cur_q};
    tgt_x     = {1'b0, target_q};
    diff      = '0;
    moved     = cur_x;
    step_word = cur_q;
    if (tgt_x > cur_x) begin
      diff  = tgt_x - cur_x;
      moved = cur_x + Step;
      step_word = (diff <= Step) ? target_q : moved[WORD_W-1:0];
    end else if (tgt_x < cur_x) begin
      diff  = cur_x - tgt_x;
      moved = cur_x - Step;
      step_word = (diff <= Step) ? target_q : moved[WORD_W-1:0];
    end
  end

  // A jump load overrides any step; a plain load coinciding with a tick still steps toward
  // the old target because step_word is built from target_q.
  always_comb begin
    target_d = word_vld ? word : target_q;
    cur_d    = cur_q;
    if (word_vld && jump) begin
      cur_d = word;
    end else if (tick) begin
      cur_d = step_word;
    end
  end

  // Row/column encoding of the current word, registered one cycle later.
  assign row_bin = cur_q[WORD_W-1:COL_W];
  assign col_bin = cur_q[COL_W-1:0];

  always_comb begin
    r_all_d = '1;
    row_d   = '0;
    col_d   = '0;
    for (int i = 0; i < NROW; i++) begin
      r_all_d[i] = !(i < int'(row_bin));
      row_d[i]   = (i == int'(row_bin));
    end
    for (int j = 0; j < NCOL; j++) begin
      if ((SERP != 0) && row_bin[0]) begin
        // Serpentine: odd rows fill from the MSB end.
        col_d[j] = (j >= NCOL - int'(col_bin));
      end else begin
        col_d[j] = (j < int'(col_bin));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      r_all_q  <= '1;
      row_q    <= {{(NROW-1){1'b0}}, 1'b1};
      col_q    <= '0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      r_all_q  <= r_all_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign r_all    = r_all_q;
  assign row      = row_q;
  assign col      = col_q;
  assign cur_word = cur_q;
  // Compare of two registers only, so no combinational input path reaches busy.
  assign busy     = (cur_q != target_q);

endmodule

// File: tb/tb_dco_arr_slew_cod.sv
// Bench for dco_arr_slew_cod: two instances (serpentine and linear fill) share stimulus and
// are compared every cycle against a behavioural model, plus literal spot checks.
module tb_dco_arr_slew_cod;

  localparam int MAX_STEP = 4;
  localparam int TICK_DIV = 2;
  localparam int NCOL     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       word_vld = 1'b0;
  logic       jump = 1'b0;
  logic [7:0] word = 8'h00;

  logic [15:0] r_all1, row1, col1, r_all0, row0, col0;
  logic [7:0]  cur1, cur0;
  logic        busy1, busy0;

  dco_arr_slew_cod #(.ROW_W(4), .COL_W(4), .WORD_W(8), .MAX_STEP(MAX_STEP),
                     .TICK_DIV(TICK_DIV), .SERP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .word(word), .word_vld(word_vld), .jump(jump),
    .r_all(r_all1), .row(row1), .col(col1), .cur_word(cur1), .busy(busy1)
  );

  dco_arr_slew_cod #(.ROW_W(4), .COL_W(4), .WORD_W(8), .MAX_STEP(MAX_STEP),
                     .TICK_DIV(TICK_DIV), .SERP(0)) dut_lin (
    .clk(clk), .rst(rst), .en(en), .word(word), .word_vld(word_vld), .jump(jump),
    .r_all(r_all0), .row(row0), .col(col0), .cur_word(cur0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          m_target, m_cur, m_cnt;
  logic [15:0] m_rall, m_row, m_col1, m_col0;

  function automatic logic [15:0] enc_rall(int w);
    int v;
    v = (65535 << (w / NCOL)) & 65535;
    return v[15:0];
  endfunction

  function automatic logic [15:0] enc_row(int w);
    int v;
    v = 1 << (w / NCOL);
    return v[15:0];
  endfunction

  function automatic logic [15:0] enc_col(int w, bit serp);
    int rb, cb, v;
    rb = w / NCOL;
    cb = w % NCOL;
    v  = (1 << cb) - 1;
    if (serp && (rb % 2 == 1)) v = v << (NCOL - cb);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_target = 0; m_cur = 0; m_cnt = 0;
    m_rall = 16'hFFFF; m_row = 16'h0001; m_col1 = 16'h0000; m_col0 = 16'h0000;
  endtask

  task automatic model_clock();
    int  d, nc;
    bit  tick;
    if (rst) begin
      model_reset();
      return;
    end
    m_rall = enc_rall(m_cur);
    m_row  = enc_row(m_cur);
    m_col1 = enc_col(m_cur, 1'b1);
    m_col0 = enc_col(m_cur, 1'b0);
    tick = en && (m_cnt == TICK_DIV - 1);
    nc   = m_cur;
    if (word_vld && jump) begin
      nc = int'(word);
    end else if (tick) begin
      d = m_target - m_cur;
      if (d > MAX_STEP)       nc = m_cur + MAX_STEP;
      else if (d < -MAX_STEP) nc = m_cur - MAX_STEP;
      else                    nc = m_target;
    end
    if (word_vld) m_target = int'(word);
    m_cur = nc;
    if (en) m_cnt = (m_cnt + 1) % TICK_DIV;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("cur_word",     32'(cur1),   32'(m_cur));
    check("busy",         32'(busy1),  32'(m_cur != m_target));
    check("r_all",        32'(r_all1), 32'(m_rall));
    check("row",          32'(row1),   32'(m_row));
    check("col_serp",     32'(col1),   32'(m_col1));
    check("cur_word_lin", 32'(cur0),   32'(m_cur));
    check("busy_lin",     32'(busy0),  32'(m_cur != m_target));
    check("r_all_lin",    32'(r_all0), 32'(m_rall));
    check("row_lin",      32'(row0),   32'(m_row));
    check("col_lin",      32'(col0),   32'(m_col0));
  endtask

  // Model advances on the active edge; outputs are compared on the falling edge.
  task automatic step_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all();
  endtask

  task automatic load(logic [7:0] w, logic j);
    word = w; word_vld = 1'b1; jump = j;
    step_cycle();
    word_vld = 1'b0; jump = 1'b0;
  endtask

  task automatic wait_model(int tgt, int budget);
    int n = 0;
    while (m_cur != tgt && n < budget) begin
      step_cycle();
      n++;
    end
    step_cycle();
  endtask

  // Called at a falling edge: raise reset between edges and check outputs right away.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_rst_rall", 32'(r_all1), 32'h0000FFFF);
    check("async_rst_row",  32'(row1),   32'h00000001);
    step_cycle();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    step_cycle();
    step_cycle();
    check("rst_cur",  32'(cur1),   32'h0);
    check("rst_rall", 32'(r_all1), 32'h0000FFFF);
    check("rst_row",  32'(row1),   32'h00000001);
    check("rst_col",  32'(col1),   32'h0);
    check("rst_busy", 32'(busy1),  32'h0);
    rst = 1'b0;
    step_cycle();

    // Jump-load 0x25
    load(8'h25, 1'b1);
    check("jmp25_cur", 32'(cur1), 32'h25);
    step_cycle();
    check("jmp25_rall", 32'(r_all1), 32'h0000FFFC);
    check("jmp25_row",  32'(row1),   32'h00000004);
    check("jmp25_col",  32'(col1),   32'h0000001F);
    check("jmp25_busy", 32'(busy1),  32'h0);

    // Jump-load 0x35: odd row, serpentine vs linear
    load(8'h35, 1'b1);
    step_cycle();
    check("jmp35_rall",    32'(r_all1), 32'h0000FFF8);
    check("jmp35_row",     32'(row1),   32'h00000008);
    check("jmp35_col",     32'(col1),   32'h0000F800);
    check("jmp35_col_lin", 32'(col0),   32'h0000001F);

    // Upward slew 0 -> 0x10
    load(8'h00, 1'b1);
    en = 1'b1;
    load(8'h10, 1'b0);
    wait_model(16, 20);
    check("up_cur",  32'(cur1),   32'h10);
    check("up_busy", 32'(busy1),  32'h0);
    check("up_row",  32'(row1),   32'h00000002);
    check("up_rall", 32'(r_all1), 32'h0000FFFE);
    check("up_col",  32'(col1),   32'h0);

    // Top code, then small and large downward slews
    load(8'hFF, 1'b1);
    step_cycle();
    check("ff_rall",    32'(r_all1), 32'h00008000);
    check("ff_row",     32'(row1),   32'h00008000);
    check("ff_col",     32'(col1),   32'h0000FFFE);
    check("ff_col_lin", 32'(col0),   32'h00007FFF);
    load(8'hFD, 1'b0);
    wait_model(253, 4);
    check("fd_cur", 32'(cur1), 32'hFD);
    load(8'h00, 1'b0);
    wait_model(0, 200);
    step_cycle();
    check("down_cur",  32'(cur1),   32'h0);
    check("down_rall", 32'(r_all1), 32'h0000FFFF);
    check("down_row",  32'(row1),   32'h00000001);

    // Mid-slew pause and re-target
    load(8'h10, 1'b0);
    wait_model(8, 20);
    en = 1'b0;
    repeat (5) step_cycle();
    check("pause_cur",  32'(cur1),  32'h08);
    check("pause_busy", 32'(busy1), 32'h1);
    en = 1'b1;
    load(8'h06, 1'b0);
    wait_model(6, 10);
    check("retgt_cur",  32'(cur1),  32'h06);
    check("retgt_busy", 32'(busy1), 32'h0);

    // Async reset mid-slew, then no motion without a new load
    load(8'hF0, 1'b0);
    repeat (5) step_cycle();
    async_reset();
    repeat (10) step_cycle();
    check("post_rst_cur",  32'(cur1),  32'h0);
    check("post_rst_busy", 32'(busy1), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      word_vld = ($urandom_range(0, 15) == 0);
      jump     = word_vld && ($urandom_range(0, 3) == 0);
      word     = 8'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      step_cycle();
    end
    word_vld = 1'b0;
    jump = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
